cache_nway: RTL



---
 rtl/cache_nway.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cache_nway.sv
// N-way set-associative, write-through, no-write-allocate cache.
// One-word lines; round-robin replacement once a set is full.
module cache_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_miss,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD, MEM_WR, RESP
  } state_t;

  state_t state_q, state_d;

  logic              r_wr;
  logic              r_miss;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] hit_data;
  logic              has_inv;
  logic [WAY_W-1:0]  vic;
  logic              fill;

  assign idx  = r_addr[IDX_W-1:0];
  assign tag  = r_addr[ADDR_W-1:IDX_W];
  assign fill = (state_q == MEM_RD) && mem_ack;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_data = data_q[w][idx];
      end
    end
  end

  // Lowest invalid way wins; otherwise fall back to the set's pointer.
  always_comb begin
    has_inv = 1'b0;
    vic     = rr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        vic     = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (r_wr)     state_d = MEM_WR;
        else if (hit) state_d = RESP;
        else          state_d = MEM_RD;
      end
      MEM_RD: if (mem_ack) state_d = RESP;
      MEM_WR: if (mem_ack) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_miss  = rsp_valid && r_miss;
  assign rsp_rdata = (rsp_valid && !r_wr) ? r_rdata : '0;
  assign mem_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_wr    = (state_q == MEM_WR);
  assign mem_addr  = mem_req ? r_addr : '0;
  assign mem_wdata = mem_wr ? r_wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr       <= 1'b0;
      r_miss     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          r_wr    <= req_wr;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
        end
        LOOKUP: begin
          r_miss  <= !hit;
          r_rdata <= hit_data;
        end
        MEM_RD: if (mem_ack) begin
          r_rdata          <= mem_rdata;
          valid_q[idx][vic] <= 1'b1;
          if (!has_inv)
            rr_q[idx] <= (rr_q[idx] == LAST_WAY) ? '0 : rr_q[idx] + 1'b1;
        end
        RESP: begin
          if (r_miss) begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
          end else begin
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP && r_wr && hit)
      data_q[hit_way][idx] <= r_wdata;
    if (fill) begin
      tag_q[vic][idx]  <= tag;
      data_q[vic][idx] <= mem_rdata;
    end
  end

endmodule
